onewire_master: RTL and testbench

//  Hardware 1-wire bus master for the DS2401/DS2433 pins; replaces host bit-banging of register 0x77.

---
 rtl/onewire_master_if.sv | 22 ++
 rtl/onewire_master.sv | 135 +++++++++++++
 tb/tb_onewire_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/onewire_master_if.sv
// Host command/result handshake and open-drain pin signals of one 1-wire bus.
interface onewire_master_if;
   logic       cmdValid;
   logic       cmdReady;
   logic [1:0] cmdOp;
   logic [8:0] cmdData;
   logic       resultValid;
   logic [7:0] resultData;
   logic       presence;
   logic       busIn;
   logic       busPullLow;

   modport master (
      input  cmdValid, cmdOp, cmdData, busIn,
      output cmdReady, resultValid, resultData, presence, busPullLow
   );

   modport slave (
      output cmdValid, cmdOp, cmdData, busIn,
      input  cmdReady, resultValid, resultData, presence, busPullLow
   );
endinterface

// File: rtl/onewire_master.sv
// 1-wire bus master: reset/presence, write-slot and read-slot timing, byte ops LSB first.
// Every state is timed in whole microseconds from its own entry.
module onewire_master #(
   parameter int unsigned CYCLES_PER_US = 29,
   parameter int unsigned T_RST_LOW     = 480,
   parameter int unsigned T_RST_SAMPLE  = 70,
   parameter int unsigned T_RST_TAIL    = 410,
   parameter int unsigned T_LOW_1       = 6,
   parameter int unsigned T_LOW_0       = 60,
   parameter int unsigned T_SAMPLE      = 15,
   parameter int unsigned T_SLOT        = 70
) (
   input logic              clock29M,
   input logic              nReset,
   onewire_master_if.master ow
);

   localparam int unsigned PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;

   localparam logic [1:0] OP_RESET = 2'd0;
   localparam logic [1:0] OP_RBIT  = 2'd2;
   localparam logic [1:0] OP_BYTE  = 2'd3;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RST_LOW   = 3'd1;
   localparam logic [2:0] S_RST_WAIT  = 3'd2;
   localparam logic [2:0] S_RST_TAIL  = 3'd3;
   localparam logic [2:0] S_SLOT_LOW  = 3'd4;
   localparam logic [2:0] S_SLOT_HIGH = 3'd5;
   localparam logic [2:0] S_NEXT      = 3'd6;
   localparam logic [2:0] S_DONE      = 3'd7;

   logic [2:0]    state, nxt;
   logic [PW-1:0] presc;
   logic [9:0]    us_cnt, dur;
   logic [1:0]    op;
   logic [7:0]    data;
   logic          rd;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          pull, res_vld, pres;
   logic [7:0]    res_data;
   logic          accept, us_tick, last, slot_bit, sample, cmd_rd;

   assign ow.cmdReady    = (state == S_IDLE);
   assign ow.busPullLow  = pull;
   assign ow.resultValid = res_vld;
   assign ow.resultData  = res_data;
   assign ow.presence    = pres;

   assign accept   = ow.cmdValid && (state == S_IDLE);
   assign cmd_rd   = (ow.cmdOp == OP_RBIT) || ((ow.cmdOp == OP_BYTE) && ow.cmdData[8]);
   assign us_tick  = (presc == PW'(CYCLES_PER_US - 1));
   assign last     = us_tick && (us_cnt == dur - 10'd1);
   // Reads use the short write-1 slot; the slave decides the level.
   assign slot_bit = rd | data[bit_idx];
   assign sample   = rd && (state == S_SLOT_HIGH) && (presc == '0) &&
                     (us_cnt == 10'(T_SAMPLE - T_LOW_1));

   always_comb begin
      dur = 10'd1;
      case (state)
         S_RST_LOW:   dur = 10'(T_RST_LOW);
         S_RST_WAIT:  dur = 10'(T_RST_SAMPLE);
         S_RST_TAIL:  dur = 10'(T_RST_TAIL);
         S_SLOT_LOW:  dur = slot_bit ? 10'(T_LOW_1) : 10'(T_LOW_0);
         S_SLOT_HIGH: dur = slot_bit ? 10'(T_SLOT - T_LOW_1) : 10'(T_SLOT - T_LOW_0);
         default:     dur = 10'd1;
      endcase
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:      if (accept) nxt = (ow.cmdOp == OP_RESET) ? S_RST_LOW : S_SLOT_LOW;
         S_RST_LOW:   if (last) nxt = S_RST_WAIT;
         S_RST_WAIT:  if (last) nxt = S_RST_TAIL;
         S_RST_TAIL:  if (last) nxt = S_DONE;
         S_SLOT_LOW:  if (last) nxt = S_SLOT_HIGH;
         S_SLOT_HIGH: if (last) nxt = S_NEXT;
         S_NEXT:      nxt = ((op == OP_BYTE) && (bit_idx < 3'd7)) ? S_SLOT_LOW : S_DONE;
         S_DONE:      nxt = S_IDLE;
         default:     nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock29M) begin
      if (!nReset) begin
         state    <= S_IDLE;
         presc    <= '0;
         us_cnt   <= '0;
         op       <= OP_RESET;
         data     <= '0;
         rd       <= 1'b0;
         bit_idx  <= '0;
         shift    <= '0;
         pull     <= 1'b0;
         res_vld  <= 1'b0;
         res_data <= '0;
         pres     <= 1'b0;
      end else begin
         state <= nxt;
         // Timebase restarts on every state change so each state is N whole us.
         if ((nxt != state) || (state == S_IDLE)) begin
            presc  <= '0;
            us_cnt <= '0;
         end else if (us_tick) begin
            presc  <= '0;
            us_cnt <= us_cnt + 10'd1;
         end else begin
            presc  <= presc + 1'b1;
         end

         pull    <= (state == S_RST_LOW) || (state == S_SLOT_LOW);
         res_vld <= (state == S_DONE);

         if (accept) begin
            op      <= ow.cmdOp;
            rd      <= cmd_rd;
            data    <= cmd_rd ? 8'hFF : ow.cmdData[7:0];
            bit_idx <= '0;
            shift   <= '0;
         end

         if ((state == S_RST_WAIT) && last) pres <= ~ow.busIn;

         if (sample) shift <= (op == OP_BYTE) ? {ow.busIn, shift[7:1]} : {7'd0, ow.busIn};

         if ((state == S_NEXT) && (bit_idx != 3'd7)) bit_idx <= bit_idx + 3'd1;

         if (state == S_DONE) res_data <= rd ? shift : 8'h00;
      end
   end

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master with a scoreboard of expected results and a slave model.
module tb_onewire_master;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   onewire_master_if ifc();

   onewire_master #(
      .CYCLES_PER_US(4), .T_RST_LOW(480), .T_RST_SAMPLE(70), .T_RST_TAIL(410),
      .T_LOW_1(6), .T_LOW_0(60), .T_SAMPLE(15), .T_SLOT(70)
   ) dut (
      .clock29M(clk),
      .nReset  (rst_n),
      .ow      (ifc.master)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic slave_low = 1'b0;
   assign ifc.busIn = ~ifc.busPullLow & ~slave_low;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus and result monitor
   logic       bpl_q = 1'b0;
   int         rise_t = 0;
   int         low_q[$];
   int         rise_q[$];
   logic [7:0] exp_q[$];
   int         rv_cnt = 0;
   int         rv_t = 0;
   always @(negedge clk) begin
      if (ifc.busPullLow === 1'b1 && !bpl_q) begin
         rise_t = cyc;
         rise_q.push_back(cyc);
      end
      if (ifc.busPullLow === 1'b0 && bpl_q) low_q.push_back(cyc - rise_t);
      bpl_q = (ifc.busPullLow === 1'b1);
      if (ifc.resultValid === 1'b1) begin
         rv_cnt++;
         rv_t = cyc;
         chk("sb_pending", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("result_data", 32'(ifc.resultData), 32'(exp_q.pop_front()));
      end
   end

   // Slave model: mode 1 answers reset with presence, mode 2 returns slave_byte LSB first
   int         mode = 0;
   logic [7:0] slave_byte = 8'h00;
   int         slave_idx = 0;
   logic       cur_bit = 1'b1;
   int         sref = -1000000;
   logic       sp_q = 1'b0;
   always @(negedge clk) begin
      if (ifc.busPullLow === 1'b1 && !sp_q && mode == 2) begin
         cur_bit = slave_byte[slave_idx % 8];
         slave_idx++;
         sref = cyc;
      end
      if (ifc.busPullLow === 1'b0 && sp_q && mode == 1) sref = cyc;
      sp_q = (ifc.busPullLow === 1'b1);
      case (mode)
         1:       slave_low = ((cyc - sref) >= 120) && ((cyc - sref) <= 720);
         // Held low only in a narrow window around slot start + 60 cycles
         2:       slave_low = !cur_bit && ((cyc - sref) >= 57) && ((cyc - sref) <= 61);
         default: slave_low = 1'b0;
      endcase
   end

   int acc_cyc = 0;

   task automatic issue(input logic [1:0] op, input logic [8:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (ifc.cmdReady !== 1'b1 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_before_issue", 32'(ifc.cmdReady), 1);
      low_q.delete();
      rise_q.delete();
      ifc.cmdValid = 1'b1;
      ifc.cmdOp    = op;
      ifc.cmdData  = d;
      acc_cyc      = cyc;
      @(negedge clk);
      ifc.cmdValid = 1'b0;
   endtask

   task automatic wait_result();
      int start, n;
      start = rv_cnt;
      n = 0;
      while (rv_cnt == start && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("result_seen", 32'(rv_cnt - start), 1);
   endtask

   task automatic reset_midop(input string tag);
      int c;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk({tag, "_pull"}, 32'(ifc.busPullLow), 0);
      chk({tag, "_ready"}, 32'(ifc.cmdReady), 1);
      chk({tag, "_presence"}, 32'(ifc.presence), 0);
      rst_n = 1'b1;
      c = rv_cnt;
      repeat (4000) @(negedge clk);
      chk({tag, "_no_result"}, 32'(rv_cnt - c), 0);
   endtask

   int wr_low[8] = '{24, 240, 24, 240, 240, 24, 240, 24};
   int c0;

   initial begin
      ifc.cmdValid = 1'b0;
      ifc.cmdOp    = 2'd0;
      ifc.cmdData  = 9'd0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ifc.cmdReady), 1);
      chk("rst_pull", 32'(ifc.busPullLow), 0);
      chk("rst_valid", 32'(ifc.resultValid), 0);
      chk("rst_data", 32'(ifc.resultData), 0);
      chk("rst_presence", 32'(ifc.presence), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // RESET with a responding slave
      mode = 1;
      sref = -1000000;
      exp_q.push_back(8'h00);
      issue(2'd0, 9'd0);
      wait_result();
      chk("rst_pulses", 32'(low_q.size()), 1);
      if (low_q.size() > 0) chk("rst_low_width", 32'(low_q[0]), 1920);
      if (rise_q.size() > 0) chk("rst_pull_latency", 32'(rise_q[0] - acc_cyc), 2);
      chk("rst_result_latency", 32'(rv_t - acc_cyc), 3842);
      chk("presence_set", 32'(ifc.presence), 1);

      // RESET with nobody on the bus clears the old presence
      mode = 0;
      exp_q.push_back(8'h00);
      issue(2'd0, 9'd0);
      wait_result();
      chk("presence_clear", 32'(ifc.presence), 0);

      // BYTE write A5h
      exp_q.push_back(8'h00);
      issue(2'd3, 9'h0A5);
      wait_result();
      chk("wr_byte_slots", 32'(low_q.size()), 8);
      for (int i = 0; i < 8 && i < low_q.size(); i++) chk($sformatf("wr_low%0d", i), 32'(low_q[i]), 32'(wr_low[i]));
      // Slot is 280 cycles, plus the single NEXT cycle between slots
      for (int i = 1; i < rise_q.size(); i++) chk($sformatf("wr_pitch%0d", i), 32'(rise_q[i] - rise_q[i-1]), 281);

      // BYTE read, slave returns 3Ch
      mode = 2;
      slave_byte = 8'h3C;
      slave_idx = 0;
      exp_q.push_back(8'h3C);
      issue(2'd3, 9'h100);
      wait_result();
      chk("rd_byte_slots", 32'(low_q.size()), 8);
      for (int i = 0; i < 8 && i < low_q.size(); i++) chk($sformatf("rd_low%0d", i), 32'(low_q[i]), 24);

      // READ_BIT 0, with a command attempt while busy
      slave_byte = 8'h00;
      slave_idx = 0;
      exp_q.push_back(8'h00);
      issue(2'd2, 9'd0);
      repeat (50) @(negedge clk);
      chk("busy_not_ready", 32'(ifc.cmdReady), 0);
      ifc.cmdValid = 1'b1;
      ifc.cmdOp    = 2'd0;
      repeat (3) @(negedge clk);
      ifc.cmdValid = 1'b0;
      wait_result();
      c0 = rv_cnt;
      repeat (4000) @(negedge clk);
      chk("busy_cmd_ignored", 32'(rv_cnt - c0), 0);
      chk("busy_cmd_no_pulse", 32'(low_q.size()), 1);

      // READ_BIT 1
      slave_byte = 8'hFF;
      slave_idx = 0;
      exp_q.push_back(8'h01);
      issue(2'd2, 9'd0);
      wait_result();

      // WRITE_BIT 0 then WRITE_BIT 1 back-to-back
      mode = 0;
      exp_q.push_back(8'h00);
      issue(2'd1, 9'd0);
      wait_result();
      if (low_q.size() > 0) chk("wbit0_low", 32'(low_q[0]), 240);
      exp_q.push_back(8'h00);
      issue(2'd1, 9'd1);
      wait_result();
      if (low_q.size() > 0) chk("wbit1_low", 32'(low_q[0]), 24);

      // Abort in RST_LOW after a presence was latched
      mode = 1;
      sref = -1000000;
      exp_q.push_back(8'h00);
      issue(2'd0, 9'd0);
      wait_result();
      chk("presence_again", 32'(ifc.presence), 1);
      mode = 0;
      issue(2'd0, 9'd0);
      repeat (500) @(negedge clk);
      reset_midop("abort_rst");

      // Abort in SLOT_LOW of a write-0
      issue(2'd1, 9'd0);
      repeat (100) @(negedge clk);
      reset_midop("abort_slot");

      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
